// File: rtl/md_run_controller.sv
// Run-level sequencer for the MD core: start pulses, timestep counting, watchdog, profiling.
// Optional perf counters (total_cycles, rl_cycles) are built only when MD_RUN_PERF_EN is defined.
module md_run_controller #(
  parameter int NUM_CELLS     = 125,
  parameter int ITER_WIDTH    = 16,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int START_GAP     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_req,
  input  logic                     abort,
  input  logic [ITER_WIDTH-1:0]    num_iters,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic [NUM_CELLS-1:0]     reading_done,
  input  logic                     mu_done,
  output logic                     start,
  output logic                     busy,
  output logic [ITER_WIDTH-1:0]    iter_count,
  output logic [TIMEOUT_WIDTH-1:0] last_iter_cycles,
  output logic                     run_done,
  output logic                     timeout_err,
  output logic [39:0]              total_cycles,
  output logic [39:0]              rl_cycles
);

  localparam int GAP_W = (START_GAP > 1) ? $clog2(START_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t                   state_q, state_d;
  logic [ITER_WIDTH-1:0]    niters_q, niters_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [ITER_WIDTH-1:0]    iter_count_q, iter_count_d;
  logic [TIMEOUT_WIDTH-1:0] last_iter_cycles_q, last_iter_cycles_d;
  logic [TIMEOUT_WIDTH-1:0] cyc_q, cyc_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     run_done_q, run_done_d;
  logic                     accept;
  logic [ITER_WIDTH-1:0]    iter_inc;

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc_cyc(input logic [TIMEOUT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [39:0] sat_inc_perf(input logic [39:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign iter_inc = iter_count_q + 1'b1;
  assign accept   = run_req && !abort && ((state_q == S_IDLE) || (state_q == S_ERR));

  always_comb begin
    state_d            = state_q;
    niters_d           = niters_q;
    tmo_d              = tmo_q;
    iter_count_d       = iter_count_q;
    last_iter_cycles_d = last_iter_cycles_q;
    cyc_d              = cyc_q;
    gap_d              = gap_q;
    timeout_err_d      = timeout_err_q;
    // run_done is registered off the DONE state, so an abort in DONE suppresses it
    run_done_d         = (state_q == S_DONE) && !abort;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (run_req) begin
            niters_d      = num_iters;
            tmo_d         = timeout_cycles;
            iter_count_d  = '0;
            timeout_err_d = 1'b0;
            state_d       = (num_iters == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cyc_d   = TIMEOUT_WIDTH'(1);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cyc_d = sat_inc_cyc(cyc_q);
          // a completion landing on the watchdog cycle still counts as success
          if (mu_done) begin
            last_iter_cycles_d = cyc_q;
            iter_count_d       = iter_inc;
            gap_d              = '0;
            state_d            = (iter_inc == niters_q) ? S_DONE : S_GAP;
          end else if ((tmo_q != '0) && (cyc_q == tmo_q)) begin
            timeout_err_d = 1'b1;
            state_d       = S_ERR;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(START_GAP - 1)) begin
            state_d = S_LAUNCH;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      niters_q           <= '0;
      tmo_q              <= '0;
      iter_count_q       <= '0;
      last_iter_cycles_q <= '0;
      cyc_q              <= '0;
      gap_q              <= '0;
      timeout_err_q      <= 1'b0;
      run_done_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      niters_q           <= niters_d;
      tmo_q              <= tmo_d;
      iter_count_q       <= iter_count_d;
      last_iter_cycles_q <= last_iter_cycles_d;
      cyc_q              <= cyc_d;
      gap_q              <= gap_d;
      timeout_err_q      <= timeout_err_d;
      run_done_q         <= run_done_d;
    end
  end

  assign start            = (state_q == S_LAUNCH);
  assign busy             = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_GAP);
  assign iter_count       = iter_count_q;
  assign last_iter_cycles = last_iter_cycles_q;
  assign run_done         = run_done_q;
  assign timeout_err      = timeout_err_q;

`ifdef MD_RUN_PERF_EN
  logic [39:0] total_q, total_d;
  logic [39:0] rl_q, rl_d;

  always_comb begin
    total_d = total_q;
    rl_d    = rl_q;
    if (accept) begin
      total_d = '0;
      rl_d    = '0;
    end else if (state_q == S_WAIT) begin
      total_d = sat_inc_perf(total_q);
      if (!(&reading_done)) begin
        rl_d = sat_inc_perf(rl_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= '0;
      rl_q    <= '0;
    end else begin
      total_q <= total_d;
      rl_q    <= rl_d;
    end
  end

  assign total_cycles = total_q;
  assign rl_cycles    = rl_q;
`else
  logic unused_perf_inputs;
  assign unused_perf_inputs = (&reading_done) ^ accept ^ (^sat_inc_perf('0));
  assign total_cycles       = '0;
  assign rl_cycles          = '0;
`endif

endmodule

// File: tb/tb_md_run_controller.sv
// Randomised run scenarios for md_run_controller, checked against a timeline model of the run rules.
module tb_md_run_controller;

  localparam int NC  = 125;
  localparam int IW  = 16;
  localparam int TW  = 24;
  localparam int GAP = 4;

  logic          clk;
  logic          rst;
  logic          run_req;
  logic          abort;
  logic [IW-1:0] num_iters;
  logic [TW-1:0] timeout_cycles;
  logic [NC-1:0] reading_done;
  logic          mu_done;
  logic          start;
  logic          busy;
  logic [IW-1:0] iter_count;
  logic [TW-1:0] last_iter_cycles;
  logic          run_done;
  logic          timeout_err;
  logic [39:0]   total_cycles;
  logic [39:0]   rl_cycles;

  md_run_controller #(
    .NUM_CELLS(NC), .ITER_WIDTH(IW), .TIMEOUT_WIDTH(TW), .START_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .abort(abort),
    .num_iters(num_iters), .timeout_cycles(timeout_cycles),
    .reading_done(reading_done), .mu_done(mu_done),
    .start(start), .busy(busy), .iter_count(iter_count),
    .last_iter_cycles(last_iter_cycles), .run_done(run_done),
    .timeout_err(timeout_err), .total_cycles(total_cycles), .rl_cycles(rl_cycles)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cycle  = 0;

  int start_q[$];
  int done_q[$];
  int dly_q[$];
  int rd_ptr = 0;
  int mu_cnt = 0;

  // expected run outcome
  int exp_st[$];
  int exp_dn;
  int exp_it;
  int exp_er;
  int exp_last;
  int exp_tot;
  int exp_rl;
  int exp_fin;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start === 1'b1) start_q.push_back(cycle);
      if (run_done === 1'b1) done_q.push_back(cycle);
    end
  end

  // core stand-in: answers each start with mu_done after the next queued delay
  initial begin
    mu_done = 1'b0;
    forever begin
      @(negedge clk);
      mu_done = 1'b0;
      if (mu_cnt > 0) begin
        mu_cnt--;
        if (mu_cnt == 0) mu_done = 1'b1;
      end
      if (start === 1'b1 && rd_ptr < dly_q.size()) begin
        mu_cnt = dly_q[rd_ptr];
        rd_ptr++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick_to(input int n);
    while (cycle < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg_at(input int n);
    do @(negedge clk); while (cycle < n);
  endtask

  task automatic req(input int n, input int t, output int c);
    @(posedge clk);
    #1;
    num_iters      = IW'(n);
    timeout_cycles = TW'(t);
    run_req        = 1'b1;
    c              = cycle;
    @(posedge clk);
    #1;
    run_req = 1'b0;
  endtask

  // timeline model: start k is issued one cycle after the previous step ends
  task automatic predict(input int c, input int n, input int t, input int d[$]);
    int s;
    s       = c + 1;
    exp_st  = {};
    exp_dn  = -1;
    exp_it  = 0;
    exp_er  = 0;
    exp_tot = 0;
    if (n == 0) begin
      exp_dn  = c + 2;
      exp_fin = c + 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_st.push_back(s);
      if (t != 0 && d[k] > t) begin
        exp_er  = 1;
        exp_tot += t;
        exp_fin = s + t + 1;
        return;
      end
      exp_tot += d[k];
      exp_it++;
      exp_last = d[k];
      if (k == n - 1) begin
        exp_dn  = s + d[k] + 2;
        exp_fin = exp_dn;
      end else begin
        s = s + d[k] + 1 + GAP;
      end
    end
  endtask

  task automatic check_run(input string tag, input int sb, input int db);
    int ns;
    int nd;
    ns = start_q.size() - sb;
    nd = done_q.size() - db;
    check_val({tag, " start_count"}, ns, exp_st.size());
    for (int k = 0; k < ns && k < exp_st.size(); k++)
      check_val($sformatf("%s start%0d_cycle", tag, k), start_q[sb + k], exp_st[k]);
    check_val({tag, " run_done_count"}, nd, (exp_dn < 0) ? 0 : 1);
    if (nd > 0 && exp_dn >= 0) check_val({tag, " run_done_cycle"}, done_q[db], exp_dn);
    check_val({tag, " iter_count"}, iter_count, exp_it);
    check_val({tag, " last_iter_cycles"}, last_iter_cycles, exp_last);
    check_val({tag, " timeout_err"}, timeout_err, exp_er);
    check_val({tag, " busy_end"}, busy, 0);
`ifdef MD_RUN_PERF_EN
    check_val({tag, " total_cycles"}, total_cycles, exp_tot);
    check_val({tag, " rl_cycles"}, rl_cycles, exp_rl);
`else
    check_val({tag, " total_cycles"}, total_cycles, 0);
    check_val({tag, " rl_cycles"}, rl_cycles, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " start"}, start, 0);
    check_val({tag, " busy"}, busy, 0);
    check_val({tag, " iter_count"}, iter_count, 0);
    check_val({tag, " last_iter_cycles"}, last_iter_cycles, 0);
    check_val({tag, " run_done"}, run_done, 0);
    check_val({tag, " timeout_err"}, timeout_err, 0);
    check_val({tag, " total_cycles"}, total_cycles, 0);
    check_val({tag, " rl_cycles"}, rl_cycles, 0);
  endtask

  initial begin
    int c;
    int s;
    int sb;
    int db;
    int n;
    int t;
    int d[$];

    rst            = 1'b0;
    run_req        = 1'b0;
    abort          = 1'b0;
    num_iters      = '0;
    timeout_cycles = '0;
    reading_done   = '1;
    exp_last       = 0;
    exp_rl         = 0;
    #23;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick_to(cycle + 3);

    // three timesteps, 20 cycles each, plus a run_req while busy that must be ignored
    sb = start_q.size(); db = done_q.size();
    req(3, 0, c);
    d = {20, 20, 20};
    predict(c, 3, 0, d);
    foreach (d[k]) dly_q.push_back(d[k]);
    tick_to(c + 6);
    num_iters = IW'(1);
    run_req   = 1'b1;
    @(posedge clk);
    #1;
    run_req = 1'b0;
    tick_to(exp_fin + 40);
    check_run("three_iters", sb, db);

    // zero timesteps
    sb = start_q.size(); db = done_q.size();
    req(0, 0, c);
    predict(c, 0, 0, d);
    tick_to(exp_fin + 10);
    check_run("zero_iters", sb, db);

    // watchdog fires on WAIT cycle 10
    sb = start_q.size(); db = done_q.size();
    req(1, 10, c);
    s = c + 1;
    d = {35};
    predict(c, 1, 10, d);
    dly_q.push_back(35);
    neg_at(s + 10);
    check_val("wdog_cycle10 busy", busy, 1);
    check_val("wdog_cycle10 timeout_err", timeout_err, 0);
    neg_at(s + 11);
    check_val("wdog_after busy", busy, 0);
    check_val("wdog_after timeout_err", timeout_err, 1);
    tick_to(exp_fin + 40);
    check_run("wdog", sb, db);

    // completion on the watchdog cycle wins
    sb = start_q.size(); db = done_q.size();
    req(1, 10, c);
    d = {10};
    predict(c, 1, 10, d);
    dly_q.push_back(10);
    tick_to(exp_fin + 40);
    check_run("wdog_tie", sb, db);

    // abort in the gap after the second of five timesteps
    sb = start_q.size(); db = done_q.size();
    req(5, 0, c);
    s = c + 1;
    dly_q.push_back(20);
    dly_q.push_back(20);
    tick_to(s + 20 + 1 + GAP + 20 + 2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    exp_st   = {s, s + 21 + GAP};
    exp_dn   = -1;
    exp_it   = 2;
    exp_er   = 0;
    exp_last = 20;
    exp_tot  = 40;
    tick_to(s + 120);
    check_run("abort_gap", sb, db);

    // reading-done coverage: not all PEs done for the first 7 WAIT cycles
    sb = start_q.size(); db = done_q.size();
    reading_done    = '1;
    reading_done[0] = 1'b0;
    req(1, 0, c);
    s = c + 1;
    d = {20};
    predict(c, 1, 0, d);
    dly_q.push_back(20);
    tick_to(s + 8);
    reading_done = '1;
    exp_rl = 7;
    tick_to(exp_fin + 40);
    check_run("perf", sb, db);
    exp_rl = 0;

    // reset in the middle of WAIT
    sb = start_q.size();
    req(2, 0, c);
    s = c + 1;
    dly_q.push_back(25);
    tick_to(s + 5);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_last = 0;
    tick_to(s + 60);
    check_val("mid_reset start_count", start_q.size() - sb, 1);
    check_val("mid_reset busy_after", busy, 0);

    // randomised runs
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 4);
      t = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 35) : 0;
      d = {};
      for (int k = 0; k < n; k++) d.push_back($urandom_range(1, 30));
      sb = start_q.size(); db = done_q.size();
      req(n, t, c);
      predict(c, n, t, d);
      for (int k = 0; k < exp_st.size(); k++) dly_q.push_back(d[k]);
      tick_to(exp_fin + 40);
      check_run($sformatf("rand%0d", r), sb, db);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
